// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: S/Cout = A + B + Cin, one bit per cycle through a single full-adder cell.
// done pulses WIDTH cycles after start is accepted; start is ignored while busy, accepted again in the done cycle.
module serial_adder #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_sum_sh;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_s;
   logic             r_cout;
   logic             r_busy;
   logic             r_done;

   logic             w_sbit;
   logic             w_carry;
   logic [WIDTH-1:0] w_sum_next;
   logic             w_last;

   assign w_sbit     = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
   assign w_carry    = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_carry) | (r_b_sh[0] & r_carry);
   assign w_sum_next = {w_sbit, r_sum_sh[WIDTH-1:1]};
   assign w_last     = (r_cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_sum_sh <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         r_s      <= '0;
         r_cout   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               // The done cycle accepts a new request directly, so back-to-back operations have no bubble.
               r_done <= 1'b0;
               if (start) begin
                  r_a_sh   <= A;
                  r_b_sh   <= B;
                  r_carry  <= Cin;
                  r_cnt    <= '0;
                  r_sum_sh <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= SHIFT;
               end else begin
                  r_state  <= IDLE;
               end
            end
            SHIFT: begin
               r_a_sh   <= r_a_sh >> 1;
               r_b_sh   <= r_b_sh >> 1;
               r_carry  <= w_carry;
               r_sum_sh <= w_sum_next;
               r_cnt    <= r_cnt + CW'(1);
               if (w_last) begin
                  r_s     <= w_sum_next;
                  r_cout  <= w_carry;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= DONE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign S    = r_s;
   assign Cout = r_cout;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vectors, random operations, back-to-back, ignored starts and mid-operation reset.
module tb_serial_adder;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Cin;
   logic [W-1:0] S;
   logic         Cout;
   logic         busy;
   logic         done;

   int n_checks = 0;
   int n_fail   = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .A    (A),
      .B    (B),
      .Cin  (Cin),
      .S    (S),
      .Cout (Cout),
      .busy (busy),
      .done (done)
   );

   always #5 clk = ~clk;

   function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      int unsigned total;
      total = int'(a) + int'(b) + int'(c);
      return (W+1)'(total);
   endfunction

   // One operation: start at a negedge, then expect busy for W samples and a single done sample.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input bit scramble, input string name);
      logic [W:0] exp;
      int bad;
      exp = ref_sum(a, b, c);
      @(negedge clk);
      A = a; B = b; Cin = c; start = 1'b1;
      @(posedge clk);
      bad = 0;
      for (int cyc = 0; cyc <= W; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (scramble && cyc < W) begin
            A     = W'($urandom);
            B     = W'($urandom);
            Cin   = 1'($urandom);
            start = 1'($urandom);
         end
         if (cyc < W) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
         end else begin
            if (busy !== 1'b0 || done !== 1'b1) bad++;
         end
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL %s_timing: %0d cycles wrong busy/done, required busy for %0d cycles then one done", name, bad, W);
      end
      n_checks++;
      if ({Cout, S} !== exp) begin
         n_fail++;
         $display("FAIL %s_result: got Cout=%b S=%b, required Cout=%b S=%b", name, Cout, S, exp[W], exp[W-1:0]);
      end
   endtask

   task automatic check_quiet(input int ncyc, input string name);
      int bad;
      bad = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         if (busy !== 1'b0 || done !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL %s_quiet: %0d cycles with busy/done active, required 0", name, bad);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
      #12;
      n_checks++;
      if (S !== '0 || Cout !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_sum: got Cout=%b S=%b, required 0/0", Cout, S);
      end
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got busy=%b done=%b, required 0/0", busy, done);
      end
      @(negedge clk);
      rst = 1'b0;
      check_quiet(3, "post_reset");
   endtask

   task automatic test_directed;
      logic [W-1:0] va [6];
      logic [W-1:0] vb [6];
      logic         vc [6];
      va = '{4'b0000, 4'b0110, 4'b0011, 4'b0001, 4'b1111, 4'b1011};
      vb = '{4'b0000, 4'b1111, 4'b1010, 4'b1110, 4'b1000, 4'b0111};
      vc = '{1'b0,    1'b0,    1'b0,    1'b1,    1'b0,    1'b1};
      for (int i = 0; i < 6; i++) run_op(va[i], vb[i], vc[i], 1'b0, $sformatf("directed%0d", i));
   endtask

   task automatic test_random;
      for (int i = 0; i < 16; i++)
         run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), $sformatf("random%0d", i));
   endtask

   task automatic test_busy_ignore;
      run_op(4'b1001, 4'b0101, 1'b1, 1'b1, "busy_ignore");
      check_quiet(W + 2, "busy_ignore");
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] va [4];
      logic [W-1:0] vb [4];
      logic         vc [4];
      logic [W:0]   exp;
      int bad;
      for (int i = 0; i < 4; i++) begin
         va[i] = W'($urandom); vb[i] = W'($urandom); vc[i] = 1'($urandom);
      end
      @(negedge clk);
      A = va[0]; B = vb[0]; Cin = vc[0]; start = 1'b1;
      @(posedge clk);
      for (int j = 0; j < 4; j++) begin
         bad = 0;
         for (int cyc = 0; cyc <= W; cyc++) begin
            @(negedge clk);
            if (cyc == 0 && j < 3) begin
               A = va[j+1]; B = vb[j+1]; Cin = vc[j+1];
            end
            if (cyc == W && j == 3) start = 1'b0;
            if (cyc < W) begin
               if (busy !== 1'b1 || done !== 1'b0) bad++;
            end else begin
               if (busy !== 1'b0 || done !== 1'b1) bad++;
            end
         end
         exp = ref_sum(va[j], vb[j], vc[j]);
         n_checks++;
         if (bad != 0) begin
            n_fail++;
            $display("FAIL b2b%0d_timing: %0d cycles wrong busy/done, required period %0d", j, bad, W + 1);
         end
         n_checks++;
         if ({Cout, S} !== exp) begin
            n_fail++;
            $display("FAIL b2b%0d_result: got Cout=%b S=%b, required Cout=%b S=%b", j, Cout, S, exp[W], exp[W-1:0]);
         end
      end
      check_quiet(3, "b2b_tail");
   endtask

   task automatic test_reset_mid_op;
      run_op(4'b1111, 4'b1111, 1'b1, 1'b0, "pre_abort");
      @(negedge clk);
      A = 4'b0101; B = 4'b0110; Cin = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if (S !== '0 || Cout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_reset: got S=%b Cout=%b busy=%b done=%b, required all 0", S, Cout, busy, done);
      end
      @(negedge clk);
      rst = 1'b0;
      check_quiet(W + 2, "abort");
      run_op(4'b0101, 4'b0110, 1'b0, 1'b0, "after_abort");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid_op();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
